// File: rtl/ts_pkt_sync_pkg.sv
// Shared types and constants for the MPEG-TS packet synchroniser.
package ts_pkt_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;

  localparam logic [7:0] TS_SYNC_BYTE  = 8'h47;
  localparam int         TS_PKT_LEN    = 188;
  localparam int         TS_PKT_LEN_RS = 204;

  function automatic logic [7:0] byte_cnt_inc(input logic [7:0] cnt, input logic [7:0] last);
    return (cnt == last) ? 8'd0 : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/ts_sync_fsm.sv
// Sync acquisition FSM: tracks byte position within the packet and qualifies
// each incoming byte as forwarded (with sop/eop/err) or dropped on sync loss.
module ts_sync_fsm
  import ts_pkt_sync_pkg::*;
#(
  parameter int         PKT_LEN   = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
  parameter int         LOCK_CNT  = 3,
  parameter int         LOSS_CNT  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       fwd,
  output logic       sop,
  output logic       eop,
  output logic       err,
  output logic       drop,
  output logic       locked
);

  localparam logic [7:0] LAST   = 8'(PKT_LEN - 1);
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  ts_state_e  state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] hit_q, hit_d;
  logic [2:0] miss_q, miss_d;
  logic       is_sync, boundary;
  logic [3:0] hit_inc, miss_inc;

  assign is_sync  = (data == SYNC_BYTE);
  assign boundary = (byte_cnt_q == 8'd0);
  assign hit_inc  = {1'b0, hit_q} + 4'd1;
  assign miss_inc = {1'b0, miss_q} + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      byte_cnt_q <= 8'd0;
      hit_q      <= 3'd0;
      miss_q     <= 3'd0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      locked     <= (state_d == LOCK);
    end
  end

  // A failed VERIFY or a lost LOCK returns to HUNT with byte_cnt at 0, so the
  // offending byte is never re-examined as a fresh sync candidate.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    if (valid) begin
      case (state_q)
        HUNT: begin
          if (is_sync) begin
            byte_cnt_d = 8'd1;
            hit_d      = 3'd1;
            miss_d     = 3'd0;
            state_d    = (LOCK_N == 4'd1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          byte_cnt_d = byte_cnt_inc(byte_cnt_q, LAST);
          if (boundary) begin
            if (is_sync) begin
              hit_d = hit_inc[2:0];
              if (hit_inc == LOCK_N) begin
                state_d = LOCK;
                miss_d  = 3'd0;
              end
            end else begin
              state_d    = HUNT;
              hit_d      = 3'd0;
              byte_cnt_d = 8'd0;
            end
          end
        end
        LOCK: begin
          byte_cnt_d = byte_cnt_inc(byte_cnt_q, LAST);
          if (boundary) begin
            if (is_sync) begin
              miss_d = 3'd0;
            end else if (miss_inc == LOSS_N) begin
              state_d    = HUNT;
              byte_cnt_d = 8'd0;
              hit_d      = 3'd0;
              miss_d     = 3'd0;
            end else begin
              miss_d = miss_inc[2:0];
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    fwd  = 1'b0;
    sop  = 1'b0;
    eop  = 1'b0;
    err  = 1'b0;
    drop = 1'b0;
    if (valid) begin
      case (state_q)
        HUNT: begin
          if (is_sync && (LOCK_N == 4'd1)) begin
            fwd = 1'b1;
            sop = 1'b1;
          end
        end
        VERIFY: begin
          if (boundary && is_sync && (hit_inc == LOCK_N)) begin
            fwd = 1'b1;
            sop = 1'b1;
          end
        end
        LOCK: begin
          if (boundary && !is_sync && (miss_inc == LOSS_N)) begin
            drop = 1'b1;
          end else begin
            fwd = 1'b1;
            sop = boundary;
            eop = (byte_cnt_q == LAST);
            err = boundary && !is_sync;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ts_pkt_sync.sv
// MPEG-TS packet synchroniser: forwards whole, sync-aligned packets with
// SOP/EOP framing and keeps packet / sync-loss statistics.
module ts_pkt_sync
  import ts_pkt_sync_pkg::*;
#(
  parameter int         PKT_LEN   = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
  parameter int         LOCK_CNT  = 3,
  parameter int         LOSS_CNT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ts_i_data,
  input  logic        ts_i_valid,
  output logic        ts_i_rdy,
  input  logic        pkt_o_rdy,
  output logic [7:0]  pkt_o_data,
  output logic        pkt_o_valid,
  output logic        pkt_o_sop,
  output logic        pkt_o_eop,
  output logic        pkt_o_err,
  output logic        sync_lock,
  output logic [31:0] pkt_cnt,
  output logic [15:0] loss_cnt
);

  logic       fwd, sop, eop, err, drop;
  logic [7:0] data_p1;
  logic       vld_p1, sop_p1, eop_p1, err_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ts_i_rdy = pkt_o_rdy;

  ts_sync_fsm #(
    .PKT_LEN   (PKT_LEN),
    .SYNC_BYTE (SYNC_BYTE),
    .LOCK_CNT  (LOCK_CNT),
    .LOSS_CNT  (LOSS_CNT)
  ) u_fsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (ts_i_data),
    .valid  (ts_i_valid),
    .fwd    (fwd),
    .sop    (sop),
    .eop    (eop),
    .err    (err),
    .drop   (drop),
    .locked (sync_lock)
  );

  // Stage p0 -> p1: qualified input byte registered onto the packet port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1  <= 8'd0;
      vld_p1   <= 1'b0;
      sop_p1   <= 1'b0;
      eop_p1   <= 1'b0;
      err_p1   <= 1'b0;
      pkt_cnt  <= 32'd0;
      loss_cnt <= 16'd0;
    end else begin
      vld_p1 <= fwd;
      sop_p1 <= fwd && sop;
      eop_p1 <= fwd && eop;
      err_p1 <= fwd && err;
      if (fwd) data_p1 <= ts_i_data;
      if (fwd && eop) pkt_cnt <= pkt_cnt + 32'd1;
      if (drop) loss_cnt <= sat_inc16(loss_cnt);
    end
  end

  assign pkt_o_data  = data_p1;
  assign pkt_o_valid = vld_p1;
  assign pkt_o_sop   = sop_p1;
  assign pkt_o_eop   = eop_p1;
  assign pkt_o_err   = err_p1;

endmodule

// File: tb/tb_ts_pkt_sync.sv
// Directed bench for ts_pkt_sync: acquisition, misalignment, sync loss,
// backpressure and mid-packet reset with hand-derived expectations.
module tb_ts_pkt_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ts_i_data;
  logic        ts_i_valid;
  logic        ts_i_rdy;
  logic        pkt_o_rdy;
  logic [7:0]  pkt_o_data;
  logic        pkt_o_valid, pkt_o_sop, pkt_o_eop, pkt_o_err;
  logic        sync_lock;
  logic [31:0] pkt_cnt;
  logic [15:0] loss_cnt;

  int errors = 0;
  int checks = 0;
  logic [10:0] out_q[$];

  always #5 clk = ~clk;

  ts_pkt_sync #(.PKT_LEN(188), .SYNC_BYTE(8'h47), .LOCK_CNT(3), .LOSS_CNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ts_i_data(ts_i_data), .ts_i_valid(ts_i_valid),
    .ts_i_rdy(ts_i_rdy), .pkt_o_rdy(pkt_o_rdy), .pkt_o_data(pkt_o_data),
    .pkt_o_valid(pkt_o_valid), .pkt_o_sop(pkt_o_sop), .pkt_o_eop(pkt_o_eop),
    .pkt_o_err(pkt_o_err), .sync_lock(sync_lock), .pkt_cnt(pkt_cnt), .loss_cnt(loss_cnt)
  );

  // Record every output strobe as {err, eop, sop, data}
  always @(negedge clk) if (pkt_o_valid === 1'b1) out_q.push_back({pkt_o_err, pkt_o_eop, pkt_o_sop, pkt_o_data});

  function automatic logic [7:0] pay(int k);
    return (k == 0) ? 8'h47 : 8'(k - 1);
  endfunction

  // Number of recorded entries that differ from a clean packet stream starting at position first_k
  function automatic int frame_errs(int start, int first_k, int n);
    int bad = 0;
    logic [10:0] exp;
    for (int j = 0; j < n; j++) begin
      int k = (first_k + j) % 188;
      exp = {1'b0, (k == 187), (k == 0), pay(k)};
      if (start + j >= out_q.size()) bad++;
      else if (out_q[start + j] !== exp) bad++;
    end
    return bad;
  endfunction

  function automatic int eop_total();
    int n = 0;
    foreach (out_q[i]) if (out_q[i][9]) n++;
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ts_i_valid = 1'b1;
    ts_i_data  = b;
    @(posedge clk); #1;
    ts_i_valid = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_range(input logic [7:0] b0, input int first, input int last, input bit mask);
    logic [7:0] b;
    for (int k = first; k <= last; k++) begin
      b = (k == 0) ? b0 : pay(k);
      if (mask && b == 8'h47) b = 8'h46;
      send_byte(b);
    end
  endtask

  task automatic send_pkt(input logic [7:0] b0);
    send_range(b0, 0, 187, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pkt_o_rdy = 1'b1; ts_i_valid = 1'b0; ts_i_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pkt_o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", pkt_o_valid); end
    checks++; if ({pkt_o_sop, pkt_o_eop, pkt_o_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {pkt_o_sop, pkt_o_eop, pkt_o_err}); end
    checks++; if (pkt_o_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", pkt_o_data); end
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL rst_lock got=%b exp=0", sync_lock); end
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL rst_pkt_cnt got=%0d exp=0", pkt_cnt); end
    checks++; if (loss_cnt !== 16'd0) begin errors++; $display("FAIL rst_loss_cnt got=%0d exp=0", loss_cnt); end
    checks++; if (ts_i_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy_hi got=%b exp=1", ts_i_rdy); end
    pkt_o_rdy = 1'b0; #1;
    checks++; if (ts_i_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy_lo got=%b exp=0", ts_i_rdy); end
    pkt_o_rdy = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_clean_stream();
    out_q.delete();
    send_pkt(8'h47);
    send_pkt(8'h47);
    @(negedge clk);
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL clean_lock_2syncs got=%b exp=0", sync_lock); end
    send_byte(8'h47);
    @(negedge clk);
    checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL clean_lock_3syncs got=%b exp=1", sync_lock); end
    send_range(8'h47, 1, 187, 1'b0);
    send_pkt(8'h47);
    send_pkt(8'h47);
    @(negedge clk);
    checks++; if (out_q.size() != 564) begin errors++; $display("FAIL clean_strobes got=%0d exp=564", out_q.size()); end
    checks++; if (frame_errs(0, 0, 564) != 0) begin errors++; $display("FAIL clean_framing bad=%0d exp=0", frame_errs(0, 0, 564)); end
    checks++; if (pkt_cnt !== 32'd3) begin errors++; $display("FAIL clean_pkt_cnt got=%0d exp=3", pkt_cnt); end
  endtask

  task automatic test_misaligned();
    pulse_reset();
    out_q.delete();
    for (int i = 0; i < 50; i++) send_byte((i == 10) ? 8'h47 : 8'(8'h10 + i));
    send_pkt(8'h47);
    send_pkt(8'h47);
    send_pkt(8'h47);
    @(negedge clk);
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL mis_lock_early got=%b exp=0", sync_lock); end
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL mis_no_partial got=%0d exp=0", out_q.size()); end
    send_pkt(8'h47);
    send_pkt(8'h47);
    @(negedge clk);
    checks++; if (out_q.size() != 376) begin errors++; $display("FAIL mis_strobes got=%0d exp=376", out_q.size()); end
    checks++; if (frame_errs(0, 0, 376) != 0) begin errors++; $display("FAIL mis_framing bad=%0d exp=0", frame_errs(0, 0, 376)); end
    checks++; if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL mis_pkt_cnt got=%0d exp=2", pkt_cnt); end
  endtask

  task automatic test_single_corrupt();
    logic [10:0] first;
    out_q.delete();
    send_pkt(8'h46);
    send_pkt(8'h47);
    @(negedge clk);
    first = (out_q.size() > 0) ? out_q[0] : 11'h7FF;
    checks++; if (out_q.size() != 376) begin errors++; $display("FAIL one_bad_strobes got=%0d exp=376", out_q.size()); end
    checks++; if (first !== {1'b1, 1'b0, 1'b1, 8'h46}) begin errors++; $display("FAIL one_bad_sop_err got=%h exp=%h", first, {1'b1, 1'b0, 1'b1, 8'h46}); end
    checks++; if (frame_errs(1, 1, 375) != 0) begin errors++; $display("FAIL one_bad_framing bad=%0d exp=0", frame_errs(1, 1, 375)); end
    checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL one_bad_lock got=%b exp=1", sync_lock); end
    checks++; if (loss_cnt !== 16'd0) begin errors++; $display("FAIL one_bad_loss got=%0d exp=0", loss_cnt); end
    checks++; if (pkt_cnt !== 32'd4) begin errors++; $display("FAIL one_bad_pkt_cnt got=%0d exp=4", pkt_cnt); end
  endtask

  task automatic test_double_corrupt();
    logic [10:0] first;
    out_q.delete();
    send_pkt(8'h46);
    send_byte(8'h46);
    @(negedge clk);
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL two_bad_lock got=%b exp=0", sync_lock); end
    checks++; if (loss_cnt !== 16'd1) begin errors++; $display("FAIL two_bad_loss got=%0d exp=1", loss_cnt); end
    checks++; if (out_q.size() != 188) begin errors++; $display("FAIL two_bad_dropped got=%0d exp=188", out_q.size()); end
    send_range(8'h47, 1, 187, 1'b1);
    for (int p = 0; p < 4; p++) send_pkt(8'h47);
    @(negedge clk);
    first = (out_q.size() > 0) ? out_q[0] : 11'h7FF;
    checks++; if (out_q.size() != 564) begin errors++; $display("FAIL two_bad_strobes got=%0d exp=564", out_q.size()); end
    checks++; if (first !== {1'b1, 1'b0, 1'b1, 8'h46}) begin errors++; $display("FAIL two_bad_first got=%h exp=%h", first, {1'b1, 1'b0, 1'b1, 8'h46}); end
    checks++; if (frame_errs(1, 1, 187) != 0) begin errors++; $display("FAIL two_bad_tail bad=%0d exp=0", frame_errs(1, 1, 187)); end
    checks++; if (frame_errs(188, 0, 376) != 0) begin errors++; $display("FAIL two_bad_relock bad=%0d exp=0", frame_errs(188, 0, 376)); end
    checks++; if (pkt_cnt !== 32'd7) begin errors++; $display("FAIL two_bad_pkt_cnt got=%0d exp=7", pkt_cnt); end
    checks++; if (sync_lock !== 1'b1) begin errors++; $display("FAIL two_bad_relocked got=%b exp=1", sync_lock); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    out_q.delete();
    send_range(8'h47, 0, 99, 1'b0);
    @(posedge clk); #1 pkt_o_rdy = 1'b0;
    #1;
    checks++; if (ts_i_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_low got=%b exp=0", ts_i_rdy); end
    repeat (40) begin
      @(negedge clk);
      if (ts_i_rdy !== 1'b0 || pkt_o_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_quiet bad_cycles=%0d exp=0", bad); end
    pkt_o_rdy = 1'b1; #1;
    checks++; if (ts_i_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_high got=%b exp=1", ts_i_rdy); end
    send_range(8'h47, 100, 187, 1'b0);
    send_pkt(8'h47);
    @(negedge clk);
    checks++; if (out_q.size() != 376) begin errors++; $display("FAIL bp_strobes got=%0d exp=376", out_q.size()); end
    checks++; if (frame_errs(0, 0, 376) != 0) begin errors++; $display("FAIL bp_framing bad=%0d exp=0", frame_errs(0, 0, 376)); end
    checks++; if (pkt_cnt !== 32'd9) begin errors++; $display("FAIL bp_pkt_cnt got=%0d exp=9", pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    out_q.delete();
    send_range(8'h47, 0, 99, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({pkt_o_valid, pkt_o_sop, pkt_o_eop, pkt_o_err} !== 4'b0000) begin errors++; $display("FAIL mrst_outs got=%b exp=0000", {pkt_o_valid, pkt_o_sop, pkt_o_eop, pkt_o_err}); end
    checks++; if (pkt_o_data !== 8'h00) begin errors++; $display("FAIL mrst_data got=%h exp=00", pkt_o_data); end
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL mrst_lock got=%b exp=0", sync_lock); end
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL mrst_pkt_cnt got=%0d exp=0", pkt_cnt); end
    checks++; if (loss_cnt !== 16'd0) begin errors++; $display("FAIL mrst_loss got=%0d exp=0", loss_cnt); end
    rst_n = 1'b1;
    send_range(8'h47, 100, 187, 1'b0);
    send_pkt(8'h47);
    send_pkt(8'h47);
    @(negedge clk);
    checks++; if (sync_lock !== 1'b0) begin errors++; $display("FAIL mrst_relock_early got=%b exp=0", sync_lock); end
    checks++; if (out_q.size() != 100) begin errors++; $display("FAIL mrst_no_tail got=%0d exp=100", out_q.size()); end
    send_pkt(8'h47);
    send_pkt(8'h47);
    @(negedge clk);
    checks++; if (out_q.size() != 476) begin errors++; $display("FAIL mrst_strobes got=%0d exp=476", out_q.size()); end
    checks++; if (frame_errs(0, 0, 100) != 0) begin errors++; $display("FAIL mrst_partial bad=%0d exp=0", frame_errs(0, 0, 100)); end
    checks++; if (frame_errs(100, 0, 376) != 0) begin errors++; $display("FAIL mrst_framing bad=%0d exp=0", frame_errs(100, 0, 376)); end
    checks++; if (eop_total() != 2) begin errors++; $display("FAIL mrst_eops got=%0d exp=2", eop_total()); end
    checks++; if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL mrst_pkt_cnt got=%0d exp=2", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean_stream();
    test_misaligned();
    test_single_corrupt();
    test_double_corrupt();
    test_backpressure();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
